// File: rtl/tx_flow_ctrl.sv
// tx_flow_ctrl: moves words main FIFO -> VC0/VC1 -> D0/D1 under almost-full
// hysteresis, raises pause toward the upstream source and traps overflow and
// out-of-range occupancy in a sticky ERROR state.
module tx_flow_ctrl #(
  parameter int CW    = 5,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          RESET_L,
  input  logic          init,
  input  logic [CW-1:0] main_fifo_low,
  input  logic [CW-1:0] main_fifo_high,
  input  logic [CW-1:0] Vco_low,
  input  logic [CW-1:0] Vco_high,
  input  logic [CW-1:0] Vc1_low,
  input  logic [CW-1:0] Vc1_high,
  input  logic [CW-1:0] Do_low,
  input  logic [CW-1:0] Do_high,
  input  logic [CW-1:0] D1_low,
  input  logic [CW-1:0] D1_high,
  input  logic [CW-1:0] main_cnt,
  input  logic [CW-1:0] vc0_cnt,
  input  logic [CW-1:0] vc1_cnt,
  input  logic [CW-1:0] d0_cnt,
  input  logic [CW-1:0] d1_cnt,
  input  logic          main_head_vc,
  input  logic          vc0_head_dst,
  input  logic          vc1_head_dst,
  output logic          pop_main,
  output logic          pop_vc0,
  output logic          pop_vc1,
  output logic          push_vc0,
  output logic          push_vc1,
  output logic          push_d0,
  output logic          push_d1,
  output logic          pause,
  output logic [2:0]    state,
  output logic          idle,
  output logic          error
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // FIFO slots in the per-FIFO arrays below
  localparam int NF     = 5;
  localparam int F_MAIN = 0;
  localparam int F_VC0  = 1;
  localparam int F_VC1  = 2;
  localparam int F_D0   = 3;
  localparam int F_D1   = 4;

  localparam logic [CW:0]   DEPTH_E = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Hysteresis: set wins over clear, otherwise the flag holds
  function automatic logic af_next(input logic af, input logic [CW:0] eff,
                                   input logic [CW-1:0] lo, input logic [CW-1:0] hi);
    logic r;
    if (eff >= {1'b0, hi}) begin
      r = 1'b1;
    end else if (eff <= {1'b0, lo}) begin
      r = 1'b0;
    end else begin
      r = af;
    end
    return r;
  endfunction

  state_t        state_r, state_base_s, state_nx_s;
  logic [CW-1:0] cnt_s   [NF];
  logic [CW-1:0] lo_in_s [NF];
  logic [CW-1:0] hi_in_s [NF];
  logic [CW-1:0] lo_r    [NF];
  logic [CW-1:0] hi_r    [NF];
  logic [CW:0]   eff_s   [NF];
  logic [NF-1:0] af_r, af_nx_s, inflight_s, over_s;
  logic          push_vc0_r, push_vc1_r, push_d0_r, push_d1_r, pause_r;
  logic          active_s, vc0_ok_s, vc1_ok_s;
  logic          pop_main_s, pop_vc0_s, pop_vc1_s;
  logic          ovf_s, err_s, any_cnt_s, keep_s;

  // Gather the per-FIFO inputs into indexable arrays
  always_comb begin
    cnt_s[F_MAIN]   = main_cnt;
    cnt_s[F_VC0]    = vc0_cnt;
    cnt_s[F_VC1]    = vc1_cnt;
    cnt_s[F_D0]     = d0_cnt;
    cnt_s[F_D1]     = d1_cnt;
    lo_in_s[F_MAIN] = main_fifo_low;
    lo_in_s[F_VC0]  = Vco_low;
    lo_in_s[F_VC1]  = Vc1_low;
    lo_in_s[F_D0]   = Do_low;
    lo_in_s[F_D1]   = D1_low;
    hi_in_s[F_MAIN] = main_fifo_high;
    hi_in_s[F_VC0]  = Vco_high;
    hi_in_s[F_VC1]  = Vc1_high;
    hi_in_s[F_D0]   = Do_high;
    hi_in_s[F_D1]   = D1_high;
  end

  // Effective occupancy (count plus our own in-flight write), next af flags, range check
  always_comb begin
    af_nx_s    = {NF{1'b0}};
    over_s     = {NF{1'b0}};
    inflight_s = {push_d1_r, push_d0_r, push_vc1_r, push_vc0_r, 1'b0};
    for (int i = 0; i < NF; i++) begin
      eff_s[i]   = {1'b0, cnt_s[i]} + {{CW{1'b0}}, inflight_s[i]};
      af_nx_s[i] = af_next(af_r[i], eff_s[i], lo_r[i], hi_r[i]);
      over_s[i]  = ({1'b0, cnt_s[i]} > DEPTH_E);
    end
  end

  // Read strobes, strict VC0-over-VC1 arbitration and error detection
  always_comb begin
    // a pending init already wins the state, so no new reads are started under it
    active_s   = (state_r == ST_ACTIVE) && !init;
    pop_main_s = active_s && (main_cnt != {CW{1'b0}})
                 && !(main_head_vc ? af_r[F_VC1] : af_r[F_VC0]);
    vc0_ok_s   = (vc0_cnt != {CW{1'b0}}) && !(vc0_head_dst ? af_r[F_D1] : af_r[F_D0]);
    vc1_ok_s   = (vc1_cnt != {CW{1'b0}}) && !(vc1_head_dst ? af_r[F_D1] : af_r[F_D0]);
    pop_vc0_s  = active_s && vc0_ok_s;
    pop_vc1_s  = active_s && !vc0_ok_s && vc1_ok_s;
    // a read whose write would land in an already-full FIFO is an overflow
    ovf_s      = (pop_main_s && (eff_s[main_head_vc ? F_VC1 : F_VC0] == DEPTH_E))
              || (pop_vc0_s  && (eff_s[vc0_head_dst ? F_D1 : F_D0] == DEPTH_E))
              || (pop_vc1_s  && (eff_s[vc1_head_dst ? F_D1 : F_D0] == DEPTH_E));
    err_s      = (|over_s) || ovf_s;
    any_cnt_s  = (main_cnt != {CW{1'b0}}) || (vc0_cnt != {CW{1'b0}}) || (vc1_cnt != {CW{1'b0}})
              || (d0_cnt != {CW{1'b0}}) || (d1_cnt != {CW{1'b0}});
  end

  // Next-state logic; error overrides every other transition
  always_comb begin
    state_base_s = state_r;
    case (state_r)
      ST_RESET:  state_base_s = ST_INIT;
      ST_INIT: begin
        if (init) state_base_s = ST_INIT;
        else      state_base_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)           state_base_s = ST_INIT;
        else if (any_cnt_s) state_base_s = ST_ACTIVE;
        else                state_base_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (init)                             state_base_s = ST_INIT;
        else if (!any_cnt_s && !(|inflight_s)) state_base_s = ST_IDLE;
        else                                  state_base_s = ST_ACTIVE;
      end
      ST_ERROR:  state_base_s = ST_ERROR;
      default:   state_base_s = ST_ERROR;
    endcase
    state_nx_s = err_s ? ST_ERROR : state_base_s;
    keep_s     = (state_nx_s != ST_ERROR);
  end

  // State, af flags, write strobes (one cycle after the read) and pause
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_r    <= ST_RESET;
      af_r       <= {NF{1'b0}};
      push_vc0_r <= 1'b0;
      push_vc1_r <= 1'b0;
      push_d0_r  <= 1'b0;
      push_d1_r  <= 1'b0;
      pause_r    <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      af_r       <= af_nx_s;
      push_vc0_r <= keep_s && pop_main_s && !main_head_vc;
      push_vc1_r <= keep_s && pop_main_s && main_head_vc;
      push_d0_r  <= keep_s && ((pop_vc0_s && !vc0_head_dst) || (pop_vc1_s && !vc1_head_dst));
      push_d1_r  <= keep_s && ((pop_vc0_s && vc0_head_dst) || (pop_vc1_s && vc1_head_dst));
      pause_r    <= (state_nx_s == ST_INIT) || (state_nx_s == ST_ERROR) || af_nx_s[F_MAIN];
    end
  end

  // Threshold registers: follow the inputs while in INIT, frozen otherwise
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < NF; i++) begin
        lo_r[i] <= {CW{1'b0}};
        hi_r[i] <= DEPTH_C;
      end
    end else if (state_r == ST_INIT) begin
      for (int i = 0; i < NF; i++) begin
        lo_r[i] <= lo_in_s[i];
        hi_r[i] <= hi_in_s[i];
      end
    end
  end

  assign pop_main = pop_main_s;
  assign pop_vc0  = pop_vc0_s;
  assign pop_vc1  = pop_vc1_s;
  assign push_vc0 = push_vc0_r;
  assign push_vc1 = push_vc1_r;
  assign push_d0  = push_d0_r;
  assign push_d1  = push_d1_r;
  assign pause    = pause_r;
  assign state    = state_r;
  assign idle     = (state_r == ST_IDLE);
  assign error    = (state_r == ST_ERROR);

endmodule

// File: tb/tb_tx_flow_ctrl.sv
// Bench for tx_flow_ctrl: directed scenarios with literal expectations, then
// randomized traffic where the bench also plays the FIFOs, all compared every
// cycle against a behavioural model of the controller.
module tb_tx_flow_ctrl;
  localparam int CW    = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RESET_L, init, main_head_vc, vc0_head_dst, vc1_head_dst;
  logic [CW-1:0] cnt_v [5];
  logic [CW-1:0] lo_v  [5];
  logic [CW-1:0] hi_v  [5];
  logic          pop_main, pop_vc0, pop_vc1, push_vc0, push_vc1, push_d0, push_d1;
  logic          pause, idle, error;
  logic [2:0]    state;

  tx_flow_ctrl #(.CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .RESET_L(RESET_L), .init(init),
    .main_fifo_low(lo_v[0]), .main_fifo_high(hi_v[0]),
    .Vco_low(lo_v[1]), .Vco_high(hi_v[1]),
    .Vc1_low(lo_v[2]), .Vc1_high(hi_v[2]),
    .Do_low(lo_v[3]), .Do_high(hi_v[3]),
    .D1_low(lo_v[4]), .D1_high(hi_v[4]),
    .main_cnt(cnt_v[0]), .vc0_cnt(cnt_v[1]), .vc1_cnt(cnt_v[2]),
    .d0_cnt(cnt_v[3]), .d1_cnt(cnt_v[4]),
    .main_head_vc(main_head_vc), .vc0_head_dst(vc0_head_dst), .vc1_head_dst(vc1_head_dst),
    .pop_main(pop_main), .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_vc0(push_vc0), .push_vc1(push_vc1), .push_d0(push_d0), .push_d1(push_d1),
    .pause(pause), .state(state), .idle(idle), .error(error)
  );

  // behavioural model: state number, flags, pending writes (index = FIFO), thresholds
  int       m_state;
  bit [4:0] m_af, m_pend;
  bit       m_pause;
  int       m_lo [5];
  int       m_hi [5];
  bit       e_pop_main, e_pop_vc0, e_pop_vc1;
  bit       auto_mode, up_req, drain0, drain1;
  int       n_cmp, n_fail;
  int       cyc;

  function void model_reset();
    m_state = 0; m_af = '0; m_pend = '0; m_pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_lo[i] = 0;
      m_hi[i] = DEPTH;
    end
  endfunction

  // reads the controller should issue now, from the current inputs
  function void model_comb();
    bit act, ok0;
    act        = (m_state == 3) && !init;
    e_pop_main = act && (cnt_v[0] != 0) && !m_af[main_head_vc ? 2 : 1];
    ok0        = (cnt_v[1] != 0) && !m_af[vc0_head_dst ? 4 : 3];
    e_pop_vc0  = act && ok0;
    e_pop_vc1  = act && !ok0 && (cnt_v[2] != 0) && !m_af[vc1_head_dst ? 4 : 3];
  endfunction

  // advance the model (and, in auto mode, the bench FIFOs) across one rising edge
  function void model_clock();
    int eff [5];
    int ns, tgt;
    bit bad, any, newp;
    bit [4:0] np;
    if (!RESET_L) begin
      model_reset();
      return;
    end
    model_comb();
    bad = 1'b0; any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      eff[i] = int'(cnt_v[i]) + int'(m_pend[i]);
      if (int'(cnt_v[i]) > DEPTH) bad = 1'b1;
      if (cnt_v[i] != 0) any = 1'b1;
    end
    if (e_pop_main && eff[main_head_vc ? 2 : 1] == DEPTH) bad = 1'b1;
    if (e_pop_vc0 && eff[vc0_head_dst ? 4 : 3] == DEPTH) bad = 1'b1;
    if (e_pop_vc1 && eff[vc1_head_dst ? 4 : 3] == DEPTH) bad = 1'b1;
    if (bad) ns = 4;
    else if (m_state == 0) ns = 1;
    else if (m_state == 4) ns = 4;
    else if (init) ns = 1;
    else if (m_state == 1) ns = 2;
    else if (m_state == 2) ns = any ? 3 : 2;
    else ns = (!any && m_pend == 0) ? 2 : 3;
    np = '0;
    if (ns != 4) begin
      if (e_pop_main) np[main_head_vc ? 2 : 1] = 1'b1;
      if (e_pop_vc0) np[vc0_head_dst ? 4 : 3] = 1'b1;
      if (e_pop_vc1) np[vc1_head_dst ? 4 : 3] = 1'b1;
    end
    if (auto_mode) begin
      tgt = int'(cnt_v[0]) - int'(e_pop_main);
      if (up_req && !m_pause && cnt_v[0] < DEPTH) tgt++;
      cnt_v[0] = CW'(tgt);
      cnt_v[1] = CW'(int'(cnt_v[1]) + int'(m_pend[1]) - int'(e_pop_vc0));
      cnt_v[2] = CW'(int'(cnt_v[2]) + int'(m_pend[2]) - int'(e_pop_vc1));
      cnt_v[3] = CW'(int'(cnt_v[3]) + int'(m_pend[3]) - int'(drain0 && cnt_v[3] != 0));
      cnt_v[4] = CW'(int'(cnt_v[4]) + int'(m_pend[4]) - int'(drain1 && cnt_v[4] != 0));
    end
    for (int i = 0; i < 5; i++) begin
      newp = m_af[i];
      if (eff[i] >= m_hi[i]) newp = 1'b1;
      else if (eff[i] <= m_lo[i]) newp = 1'b0;
      m_af[i] = newp;
    end
    if (m_state == 1) begin
      for (int i = 0; i < 5; i++) begin
        m_lo[i] = int'(lo_v[i]);
        m_hi[i] = int'(hi_v[i]);
      end
    end
    m_pend  = np;
    m_pause = (ns == 1 || ns == 4) ? 1'b1 : m_af[0];
    m_state = ns;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_clock();
  endtask

  // full-output comparison against the model, sampled mid-cycle
  task automatic compare();
    logic [12:0] exp_v, act_v;
    if (!RESET_L) model_reset();
    model_comb();
    #3;
    exp_v = {e_pop_main, e_pop_vc0, e_pop_vc1, m_pend[1], m_pend[2], m_pend[3], m_pend[4],
             m_pause, (m_state == 2), (m_state == 4), 3'(m_state)};
    act_v = {pop_main, pop_vc0, pop_vc1, push_vc0, push_vc1, push_d0, push_d1,
             pause, idle, error, state};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL outputs at cycle %0d: got %b expected %b", cyc, act_v, exp_v);
    end
  endtask

  task automatic randomize_inputs();
    int lo;
    if (!RESET_L) RESET_L = 1'b1;
    else RESET_L = ($urandom_range(0, 199) != 0);
    init         = ($urandom_range(0, 99) < 3);
    main_head_vc = 1'($urandom_range(0, 1));
    vc0_head_dst = 1'($urandom_range(0, 1));
    vc1_head_dst = 1'($urandom_range(0, 1));
    up_req       = 1'($urandom_range(0, 1));
    drain0       = ($urandom_range(0, 2) == 0);
    drain1       = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < 5; i++) begin
      lo      = $urandom_range(0, 3);
      lo_v[i] = CW'(lo);
      hi_v[i] = CW'($urandom_range(lo + 1, DEPTH));
    end
  endtask

  int ramp [6] = '{5, 6, 5, 4, 3, 2};
  int ramp_pause [6] = '{0, 1, 1, 1, 1, 0};

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; auto_mode = 1'b0;
    up_req = 1'b0; drain0 = 1'b0; drain1 = 1'b0;
    init = 1'b1; main_head_vc = 1'b0; vc0_head_dst = 1'b0; vc1_head_dst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cnt_v[i] = '0; lo_v[i] = CW'(2); hi_v[i] = CW'(6);
    end
    RESET_L = 1'b1;
    #2 RESET_L = 1'b0;
    model_reset();

    // reset values, then release with init held: states 0,1,1,2
    tick(); compare();
    check("rst_state", state, 0); check("rst_pause", pause, 0); check("rst_error", error, 0);
    tick(); RESET_L = 1'b1; compare();
    check("rel_state", state, 0);
    tick(); compare();
    check("init_state_a", state, 1); check("init_pause", pause, 1);
    tick(); init = 1'b0; compare();
    check("init_state_b", state, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      lo_v[i] = CW'(0); hi_v[i] = CW'(1);
    end
    compare();
    check("idle_state", state, 2); check("idle_flag", idle, 1);

    // main backpressure with frozen 6/2 thresholds
    for (int k = 0; k < 6; k++) begin
      tick(); cnt_v[0] = CW'(ramp[k]); compare();
      if (k > 0) check("pause_ramp", pause, ramp_pause[k-1]);
    end
    tick(); cnt_v[0] = '0; compare();
    check("pause_low2", pause, ramp_pause[5]);
    for (int k = 0; k < 3; k++) begin
      tick(); compare();
    end
    check("drain_idle", state, 2);

    // routing latency: pop_main at N, push_vc1 at N+1
    tick(); main_head_vc = 1'b1; cnt_v[0] = CW'(1); compare();
    tick(); compare();
    check("route_pop", pop_main, 1); check("route_active", state, 3);
    tick(); cnt_v[0] = '0; compare();
    check("route_push_vc1", push_vc1, 1); check("route_push_vc0", push_vc0, 0);
    check("route_no_pop", pop_main, 0);

    // arbiter priority and D0 almost-full blocking
    tick(); cnt_v[1] = CW'(3); cnt_v[2] = CW'(3); compare();
    check("arb_vc0", pop_vc0, 1); check("arb_vc0_only", pop_vc1, 0);
    tick(); cnt_v[1] = '0; compare();
    check("arb_vc1", pop_vc1, 1); check("arb_vc1_only", pop_vc0, 0);
    tick(); cnt_v[3] = CW'(6); compare();
    tick(); cnt_v[1] = CW'(3); compare();
    check("arb_af_vc0", pop_vc0, 0); check("arb_af_vc1", pop_vc1, 0);

    // init in the cycle after a main read: write completes, no new reads
    tick(); cnt_v[1] = '0; cnt_v[2] = '0; cnt_v[3] = '0; main_head_vc = 1'b0; cnt_v[0] = CW'(1);
    compare();
    check("mid_pop", pop_main, 1);
    tick(); init = 1'b1; compare();
    check("mid_push", push_vc0, 1); check("mid_no_pop", pop_main, 0);
    tick(); compare();
    check("mid_state", state, 1); check("mid_no_pop2", pop_main, 0);
    check("mid_no_push", push_vc0, 0);

    // error path: out-of-range count, sticky through init, cleared by reset
    tick(); init = 1'b0; cnt_v[0] = '0; compare();
    tick(); cnt_v[2] = CW'(9); compare();
    tick(); compare();
    check("err_state", state, 4); check("err_flag", error, 1); check("err_pause", pause, 1);
    check("err_strobes", {pop_main, pop_vc0, pop_vc1, push_vc0, push_vc1, push_d0, push_d1}, 0);
    tick(); init = 1'b1; cnt_v[2] = '0; compare();
    check("err_sticky_a", state, 4);
    tick(); init = 1'b0; compare();
    check("err_sticky_b", state, 4); check("err_flag_b", error, 1);
    tick(); RESET_L = 1'b0; compare();
    check("err_clr_state", state, 0); check("err_clr_flag", error, 0);
    check("err_clr_pause", pause, 0);

    // randomized traffic with the bench acting as the five FIFOs
    tick(); RESET_L = 1'b1; init = 1'b1; compare();
    auto_mode = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      tick(); randomize_inputs(); compare();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_flow_ctrl.md
TX_FLOW_CTRL -- requirements
Module: tx_flow_ctrl

Interface
REQ-001 The block SHALL have parameter CW, default 5, giving the width of every threshold and occupancy-count bus.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the capacity in words of every FIFO it controls.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and RESET_L.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-005 Port RESET_L SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-006 Port init SHALL be an input, 1 bit wide; while high, the block loads thresholds.
REQ-007 The threshold ports SHALL be inputs, CW bits each: main_fifo_low, main_fifo_high, Vco_low, Vco_high, Vc1_low, Vc1_high, Do_low, Do_high, D1_low, D1_high.
REQ-008 The occupancy ports SHALL be inputs, CW bits each: main_cnt, vc0_cnt, vc1_cnt, d0_cnt, d1_cnt, giving the current fill level of each FIFO.
REQ-009 Port main_head_vc SHALL be an input, 1 bit wide, giving the target VC of the main FIFO head word (0 = VC0, 1 = VC1).
REQ-010 Ports vc0_head_dst and vc1_head_dst SHALL be inputs, 1 bit each, giving the destination of the VC head word (0 = D0, 1 = D1).
REQ-011 Ports pop_main, pop_vc0 and pop_vc1 SHALL be outputs, 1 bit each, and are the read strobes to those FIFOs.
REQ-012 Ports push_vc0, push_vc1, push_d0 and push_d1 SHALL be outputs, 1 bit each, and are the write strobes to those FIFOs.
REQ-013 Port pause SHALL be an output, 1 bit wide, and is the backpressure signal to the upstream PUSH_MAIN source.
REQ-014 Port state SHALL be an output, 3 bits wide, with encoding RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-015 Ports idle and error SHALL be outputs, 1 bit each, decoded from state.

Function
REQ-016 The FSM SHALL have these transitions:
- RESET to INIT on the first clk after RESET_L deasserts.
- INIT to IDLE when init=0.
- IDLE to ACTIVE when any count is nonzero.
- ACTIVE to IDLE when all counts are zero and no push is in flight.
REQ-017 Any state except RESET and ERROR SHALL go to INIT when init=1; that transition takes priority over all others except ERROR.
REQ-018 In INIT, the block SHALL register all ten thresholds every cycle; the thresholds are frozen in all other states.
REQ-019 Each FIFO SHALL have an almost-full flag af_x with hysteresis:
- Effective count eff_x = count + 1 if a push to x is in flight, else count (width CW+1, no wrap).
- af_x sets when eff_x >= high_x.
- af_x clears when eff_x <= low_x.
- af_x otherwise holds.
REQ-020 pause SHALL equal af_main, registered, and SHALL also be 1 in INIT and ERROR.
REQ-021 pop_main SHALL be 1 only in ACTIVE, when main_cnt != 0 and af of the VC selected by main_head_vc is 0.
REQ-022 push_vc0 or push_vc1 SHALL assert exactly one cycle after pop_main, selected by main_head_vc as registered at pop time (FIFO read latency 1).
REQ-023 The VC-to-D arbiter SHALL use strict priority:
- pop_vc0 when in ACTIVE, vc0_cnt != 0, and the D FIFO selected by vc0_head_dst is not af.
- Otherwise pop_vc1 under the same rule using vc1_cnt and vc1_head_dst.
- Never both in the same cycle.
REQ-024 push_d0 or push_d1 SHALL assert one cycle after the VC pop, selected by the head_dst registered at pop time.
REQ-025 A push already in flight SHALL complete even if the state leaves ACTIVE; no new pops SHALL issue outside ACTIVE.
REQ-026 A simultaneous pop and push on the same FIFO SHALL be allowed; eff_x uses the count input plus the in-flight push only.
REQ-027 Any count input > DEPTH, or a push generated while eff_x == DEPTH, SHALL force ERROR on the next clk.
REQ-028 ERROR SHALL be sticky until RESET_L; in ERROR all pop and push outputs are 0, error=1, and pause=1.
REQ-029 idle SHALL be 1 only in IDLE.

Reset
REQ-030 RESET_L=0 SHALL asynchronously clear all strobes and error to 0, set pause to 0, set state to RESET, and clear all af flags and in-flight registers.
REQ-031 Reset SHALL set every low threshold to 0 and every high threshold to DEPTH.
REQ-032 Reset asserted mid-transfer SHALL abort the in-flight push with no strobe emitted.

Verification
REQ-033 Init sequence: release reset with init=1 and main_fifo_high=6, low=2, then init=0 -> state goes 0, 1, 1, 2, and the thresholds are frozen at 6/2.
REQ-034 Main backpressure: raise main_cnt 0 to 6 -> pause=1 at count 6 and stays 1 at 5..3; lower to 2 -> pause=0.
REQ-035 Routing latency: main_cnt=1 with main_head_vc=1 in ACTIVE -> pop_main at cycle N, push_vc1 at N+1, push_vc0 stays 0.
REQ-036 Arbiter priority: vc0_cnt=3 and vc1_cnt=3, both dst=0, D0 not af -> only pop_vc0 pulses; with vc0_cnt=0 -> pop_vc1 pulses; with af_d0 set -> neither pops.
REQ-037 Error path: drive vc1_cnt=9 with DEPTH=8 -> state=4 and error=1, all strobes 0, held through an init pulse, cleared only by RESET_L.
REQ-038 Mid-flight init: assert init in the cycle after pop_main -> the push still occurs next cycle, state=1, and no further pops.
